// File: rtl/wb_uart_rx_if.sv
// rtl/wb_uart_rx_if.sv - Wishbone classic bus bundle between the J1 master and wb_uart_rx
// Signals:
//   wb_cyc_i, wb_stb_i, wb_we_i   master -> slave cycle, strobe, write enable
//   wb_adr_i                      master -> slave register select (0 DATA, 1 STATUS)
//   wb_dat_i[15:0]                master -> slave write data
//   wb_dat_o[15:0], wb_ack_o      slave -> master read data and acknowledge
interface wb_uart_rx_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_uart_rx.sv
// rtl/wb_uart_rx.sv - Wishbone classic UART receiver with a small byte FIFO
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   wb       wb_uart_rx_if.slave: DATA (adr 0, read pops) and STATUS (adr 1, W1C bits 4:2)
//   rxd      asynchronous serial input, idle high
//   irq      high while the FIFO holds data or an error flag is set
// Configuration macro: UART_RX_PARITY_EN selects 8E1 frames with a PARITY state;
// without it frames are 8N1 and STATUS bit4 reads 0.
module wb_uart_rx #(
  parameter int waitcycles = 0,
  parameter int BAUD_DIV   = 434,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  wb_uart_rx_if.slave wb,
  input  logic        rxd,
  output logic        irq
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (waitcycles > 0) ? $clog2(waitcycles + 1) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Synchroniser plus one extra stage so a falling edge can be detected
  logic sync1_q, sync2_q, prev_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic          push, ferr_set, perr_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bitn_q    <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitn_q    <= bitn_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
    end
  end

  // The counter counts down; a state acts only on the edge where it reads zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitn_d    = bitn_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    perr_set  = 1'b0;
    if (state_q == S_IDLE) begin
      if (prev_q && !sync2_q) begin
        state_d = S_START;
        cnt_d   = CNT_HALF;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = CNT_FULL;
      case (state_q)
        S_START: begin
          if (sync2_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bitn_d    = 3'd0;
            par_err_d = 1'b0;
          end
        end
        S_DATA: begin
          shift_d = {sync2_q, shift_q[7:1]};
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          // Even parity: data plus parity bit must hold an even number of ones
          par_err_d = ^{shift_q, sync2_q};
          perr_set  = ^{shift_q, sync2_q};
          state_d   = S_STOP;
        end
`endif
        S_STOP: begin
          state_d = S_IDLE;
          if (!sync2_q)        ferr_set = 1'b1;
          else if (!par_err_q) push     = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q;
  logic          empty, full, pop, do_push, ovr_set;
  logic          ovr_q, ferr_q, perr_q;
  logic          ack_q, pop_pend_q, irq_q;
  logic [2:0]    clr_pend_q, clr;
  logic [15:0]   dat_q, status;
  logic [WW-1:0] wait_q;
  logic          req, unused_dat;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == 3'd0);
  assign full    = (count_q == 3'(DEPTH));
  // Pop and W1C are held from the ack-raising edge and applied at the edge ending ack
  assign pop     = ack_q & pop_pend_q;
  assign clr     = ack_q ? clr_pend_q : 3'b000;
  // A simultaneous pop frees a slot, so a push into a full FIFO is kept then
  assign do_push = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + 3'(do_push) - 3'(pop);
      ovr_q   <= (ovr_q  & ~clr[0]) | ovr_set;
      ferr_q  <= (ferr_q & ~clr[1]) | ferr_set;
      perr_q  <= (perr_q & ~clr[2]) | perr_set;
      irq_q   <= ~empty | ovr_q | ferr_q | perr_q;
    end
  end

  // Bus side
  assign status     = {5'b0, count_q, 3'b0, perr_q, ferr_q, ovr_q, full, ~empty};
  assign req        = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign unused_dat = ^{wb.wb_dat_i[15:5], wb.wb_dat_i[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      wait_q     <= '0;
      pop_pend_q <= 1'b0;
      clr_pend_q <= '0;
    end else begin
      ack_q <= 1'b0;
      if (req) begin
        if (wait_q == WW'(waitcycles)) begin
          ack_q      <= 1'b1;
          wait_q     <= '0;
          pop_pend_q <= ~wb.wb_we_i & ~wb.wb_adr_i & ~empty;
          clr_pend_q <= (wb.wb_we_i & wb.wb_adr_i) ? wb.wb_dat_i[4:2] : 3'b000;
          if (wb.wb_we_i)      dat_q <= '0;
          else if (wb.wb_adr_i) dat_q <= status;
          else if (empty)      dat_q <= '0;
          else                 dat_q <= {8'h00, mem_q[rd_ptr_q]};
        end else begin
          wait_q <= wait_q + 1'b1;
        end
      end else if (!(wb.wb_cyc_i && wb.wb_stb_i)) begin
        wait_q <= '0;
      end
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq         = irq_q;
endmodule
